ir_packet_tx: RTL and testbench

//  Parametrised IR remote-control packet transmitter for the bus-mapped car peripheral.

---
 rtl/ir_packet_tx.sv | 142 ++++++++++++++
 tb/tb_ir_packet_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_tx.sv
// rtl/ir_packet_tx.sv - IR remote-control packet transmitter with busy/done handshake and auto-repeat
module ir_packet_tx #(
  parameter int CMD_BITS    = 4,
  parameter int HCYC_PULSE  = 1249,
  parameter int SZ_START    = 87,
  parameter int SZ_CARSEL   = 21,
  parameter int SZ_GAP      = 39,
  parameter int SZ_ASSERT   = 43,
  parameter int SZ_DEASSERT = 21,
  parameter int CTR_WIDTH   = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CMD_BITS-1:0] COMMAND,
  input  logic                SEND_PACKET,
  input  logic                REPEAT,
  output logic                BUSY,
  output logic                DONE,
  output logic                IR_LED
);

  localparam int HC_W = (HCYC_PULSE > 0) ? $clog2(HCYC_PULSE + 1) : 1;
  localparam int BI_W = (CMD_BITS > 1) ? $clog2(CMD_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, GAP, CARSEL, BIT} state_t;

  state_t                state, state_n;
  state_t                gap_next, gap_next_n;
  logic [BI_W-1:0]       bit_idx, bit_idx_n;
  logic [CTR_WIDTH-1:0]  fld_cnt, fld_cnt_n;
  logic [CTR_WIDTH-1:0]  limit;
  logic [CMD_BITS-1:0]   cmd_q;
  logic [HC_W-1:0]       hc_cnt;
  logic                  phase;
  logic                  hc_wrap, tick, envelope, last_bit;
  logic                  busy_n, done_n, load_cmd;

  assign hc_wrap  = (hc_cnt == HC_W'(HCYC_PULSE));
  assign tick     = BUSY & phase & hc_wrap;
  assign envelope = (state == START) || (state == CARSEL) || (state == BIT);
  assign last_bit = (bit_idx == BI_W'(CMD_BITS - 1));

  always_comb begin
    limit = '0;
    case (state)
      START:   limit = CTR_WIDTH'(SZ_START);
      CARSEL:  limit = CTR_WIDTH'(SZ_CARSEL);
      GAP:     limit = CTR_WIDTH'(SZ_GAP);
      BIT:     limit = cmd_q[bit_idx] ? CTR_WIDTH'(SZ_ASSERT) : CTR_WIDTH'(SZ_DEASSERT);
      default: limit = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    gap_next_n = gap_next;
    bit_idx_n  = bit_idx;
    fld_cnt_n  = fld_cnt;
    busy_n     = BUSY;
    done_n     = 1'b0;
    load_cmd   = 1'b0;
    if (state == IDLE) begin
      if (SEND_PACKET) begin
        state_n   = START;
        busy_n    = 1'b1;
        load_cmd  = 1'b1;
        fld_cnt_n = '0;
      end
    end else if (tick) begin
      if (fld_cnt == limit) begin
        fld_cnt_n = '0;
        case (state)
          START: begin
            state_n    = GAP;
            gap_next_n = CARSEL;
          end
          CARSEL: begin
            state_n    = GAP;
            gap_next_n = BIT;
            bit_idx_n  = '0;
          end
          GAP: state_n = gap_next;
          BIT: begin
            if (last_bit) begin
              done_n = 1'b1;
              // Back-to-back restart keeps the carrier running untouched.
              if (REPEAT || SEND_PACKET) begin
                state_n  = START;
                load_cmd = 1'b1;
              end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
              end
            end else begin
              state_n    = GAP;
              gap_next_n = BIT;
              bit_idx_n  = bit_idx + BI_W'(1);
            end
          end
          default: state_n = IDLE;
        endcase
      end else begin
        fld_cnt_n = fld_cnt + CTR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      gap_next <= CARSEL;
      bit_idx  <= '0;
      fld_cnt  <= '0;
      cmd_q    <= '0;
      hc_cnt   <= '0;
      phase    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      IR_LED   <= 1'b0;
    end else begin
      state    <= state_n;
      gap_next <= gap_next_n;
      bit_idx  <= bit_idx_n;
      fld_cnt  <= fld_cnt_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      IR_LED   <= envelope & phase;
      if (load_cmd) cmd_q <= COMMAND;
      // Carrier is held at phase 0 while idle, so every accept starts a fresh period.
      if (!BUSY) begin
        hc_cnt <= '0;
        phase  <= 1'b0;
      end else if (hc_wrap) begin
        hc_cnt <= '0;
        phase  <= ~phase;
      end else begin
        hc_cnt <= hc_cnt + HC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ir_packet_tx.sv
// tb/tb_ir_packet_tx.sv - directed self-checking bench for ir_packet_tx
module tb_ir_packet_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       REPEAT;
  logic       BUSY;
  logic       DONE;
  logic       IR_LED;

  int total = 0;
  int bad   = 0;
  int busy_len, done_cnt, done_pos, drop_pos, led_cnt, nseg, carrier_err;
  int drops, d1, d2, dn, quiet_busy, quiet_done;
  int seg [0:15];
  logic led_tr [0:1023];
  bit timed_out;

  ir_packet_tx #(
    .CMD_BITS(4), .HCYC_PULSE(1), .SZ_START(3), .SZ_CARSEL(1), .SZ_GAP(1),
    .SZ_ASSERT(3), .SZ_DEASSERT(1), .CTR_WIDTH(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .SEND_PACKET(SEND_PACKET),
    .REPEAT(REPEAT), .BUSY(BUSY), .DONE(DONE), .IR_LED(IR_LED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic send(input logic [3:0] cmd);
    COMMAND     = cmd;
    SEND_PACKET = 1'b1;
    cyc();
    SEND_PACKET = 1'b0;
  endtask

  // Cycle k=1 is the first cycle with BUSY high; sampling continues 4 cycles past the drop.
  task automatic measure(input int poke_at);
    int  zrun;
    bit  seen_drop;
    busy_len = 0; done_cnt = 0; done_pos = -1; drop_pos = -1;
    led_cnt = 0; nseg = 0; zrun = 99; seen_drop = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 16; i++) seg[i] = 0;
    for (int k = 1; k < 1000; k++) begin
      led_tr[k] = IR_LED;
      if (BUSY) busy_len++;
      if (DONE) begin
        done_cnt++;
        if (done_pos < 0) done_pos = k;
      end
      if (IR_LED) begin
        if (zrun > 2) nseg++;
        if (nseg >= 1 && nseg <= 16) seg[nseg-1]++;
        led_cnt++;
        zrun = 0;
      end else begin
        zrun++;
      end
      if (!BUSY && !seen_drop) begin
        seen_drop = 1'b1;
        drop_pos  = k;
      end
      if (seen_drop && k >= drop_pos + 4) begin
        timed_out = 1'b0;
        break;
      end
      SEND_PACKET = (k == poke_at);
      if (k == poke_at) COMMAND = 4'hF;
      cyc();
    end
    SEND_PACKET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; COMMAND = 4'h0; SEND_PACKET = 1'b0; REPEAT = 1'b0;
    cyc(); cyc();
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_led", IR_LED, 0);
    RESET = 1'b0;
    cyc(); cyc();

    // Command 0000: 24 carrier periods, 14 of them bursts at 2 high clocks each.
    send(4'b0000);
    measure(0);
    check("p0_timeout", timed_out, 0);
    check("p0_busy_len", busy_len, 96);
    check("p0_done_cnt", done_cnt, 1);
    check("p0_done_with_drop", done_pos, drop_pos);
    check("p0_led_high", led_cnt, 28);
    check("p0_nseg", nseg, 6);
    check("p0_seg_start", seg[0], 8);
    check("p0_seg_bit0", seg[2], 4);
    carrier_err = 0;
    if (led_tr[1] !== 1'b0) carrier_err++;
    for (int j = 0; j < 16; j++)
      if (led_tr[2+j] !== (((j % 4) >= 2) ? 1'b1 : 1'b0)) carrier_err++;
    check("start_carrier_pattern", carrier_err, 0);
    cyc(); cyc();

    send(4'b1111);
    measure(0);
    check("p15_busy_len", busy_len, 128);
    check("p15_led_high", led_cnt, 44);
    check("p15_done_cnt", done_cnt, 1);
    cyc(); cyc();

    // 0101: bits 0 and 2 are 4-period (16-clock) bursts, bits 1 and 3 are 2-period (8-clock).
    send(4'b0101);
    measure(0);
    check("p5_busy_len", busy_len, 112);
    check("p5_nseg", nseg, 6);
    check("p5_seg_bit0", seg[2], 8);
    check("p5_seg_bit1", seg[3], 4);
    check("p5_seg_bit2", seg[4], 8);
    check("p5_seg_bit3", seg[5], 4);
    cyc(); cyc();

    send(4'b0000);
    measure(20);
    check("ign_busy_len", busy_len, 96);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_seg_bit0", seg[2], 4);
    check("ign_seg_bit3", seg[5], 4);
    cyc(); cyc();

    REPEAT = 1'b1;
    send(4'b0000);
    drops = 0; d1 = -1; d2 = -1; dn = 0;
    for (int k = 1; k <= 290; k++) begin
      if (!BUSY) drops++;
      if (DONE) begin
        dn++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      cyc();
    end
    check("rep_busy_drops", drops, 0);
    check("rep_done_cnt", dn, 3);
    check("rep_first_done", d1, 97);
    check("rep_second_done", d2, 193);
    REPEAT = 1'b0;
    begin : wait_idle
      int n;
      n = 0;
      while (BUSY && n < 300) begin
        cyc();
        n++;
      end
      check("rep_stop_timeout", BUSY, 0);
    end
    cyc(); cyc();

    send(4'b0000);
    for (int k = 1; k < 50; k++) cyc();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    check("abort_busy", BUSY, 0);
    check("abort_led", IR_LED, 0);
    check("abort_done", DONE, 0);
    quiet_busy = 0; quiet_done = 0;
    for (int k = 0; k < 150; k++) begin
      if (BUSY) quiet_busy++;
      if (DONE) quiet_done++;
      cyc();
    end
    check("abort_no_restart", quiet_busy, 0);
    check("abort_no_done", quiet_done, 0);
    send(4'b0000);
    measure(0);
    check("after_abort_busy_len", busy_len, 96);
    check("after_abort_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
